// File: rtl/bin_accum_pack_if.sv
// Stream bundle between the popcount consumer and its neighbours: partial sums in, packed activations out.
// Latency: none, this is wiring only.
// Backpressure: none; the producer drives i_val freely and the consumer must take o_val when it pulses.
interface bin_accum_pack_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 64
);
    logic             i_val;
    logic [IN_W-1:0]  stream_i;
    logic             flush;
    logic             o_val;
    logic [OUT_W-1:0] stream_o;

    // Upstream side: drives partial sums and flush, observes packed words.
    modport master (
        output i_val,
        output stream_i,
        output flush,
        input  o_val,
        input  stream_o
    );

    // Accumulator/packer side.
    modport slave (
        input  i_val,
        input  stream_i,
        input  flush,
        output o_val,
        output stream_o
    );
endinterface

// File: rtl/bin_accum_pack.sv
// Accumulates N_CHUNKS signed partial sums per neuron, thresholds each neuron and packs the bits into OUT_W-bit words.
// Latency: o_val pulses the cycle after the edge that completes a word or takes a flush with bits pending.
// Backpressure: none; i_val may gap arbitrarily, state holds while idle, and the output is a one-cycle pulse.
module bin_accum_pack #(
    parameter int                       IN_W      = 8,
    parameter int                       ACC_W     = 16,
    parameter int                       N_CHUNKS  = 4,
    parameter int                       OUT_W     = 64,
    parameter logic signed [ACC_W-1:0]  THRESHOLD = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_accum_pack_if.slave      bus
);
    localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int BW = $clog2(OUT_W);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(OUT_W - 1);

    // The accumulator must hold N_CHUNKS worst-case partial sums without wrapping.
    generate
        if (ACC_W < IN_W + $clog2(N_CHUNKS) + 1) begin : g_acc_w_chk
            $error("bin_accum_pack: ACC_W too narrow for IN_W and N_CHUNKS");
        end
    endgenerate

    logic [CW-1:0]           chunk_cnt_q, chunk_cnt_d;
    logic [BW-1:0]           bit_cnt_q,   bit_cnt_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic [OUT_W-1:0]        pack_q,      pack_d;
    logic                    o_val_q,     o_val_d;
    logic [OUT_W-1:0]        stream_o_q,  stream_o_d;

    logic signed [ACC_W-1:0] sum;
    logic                    neuron_done;
    logic                    word_done;
    logic                    act_bit;
    logic [OUT_W-1:0]        pack_upd;

    // Next-state: accumulate the incoming chunk, pack a finished neuron, then let flush override.
    always_comb begin
        // First chunk of a neuron restarts from zero so no explicit acc clear is needed on completion.
        sum         = ((chunk_cnt_q == '0) ? '0 : acc_q)
                      + {{(ACC_W - IN_W){bus.stream_i[IN_W-1]}}, bus.stream_i};
        neuron_done = bus.i_val && (chunk_cnt_q == LAST_CHUNK);
        word_done   = neuron_done && (bit_cnt_q == LAST_BIT);
        act_bit     = (sum >= THRESHOLD);

        pack_upd = pack_q;
        if (neuron_done) begin
            pack_upd[bit_cnt_q] = act_bit;
        end

        chunk_cnt_d = chunk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        pack_d      = pack_q;
        o_val_d     = 1'b0;
        stream_o_d  = stream_o_q;

        if (bus.i_val) begin
            acc_d       = sum;
            chunk_cnt_d = neuron_done ? '0 : chunk_cnt_q + CW'(1);
        end

        if (word_done) begin
            o_val_d    = 1'b1;
            stream_o_d = pack_upd;
            pack_d     = '0;
            bit_cnt_d  = '0;
        end else if (neuron_done) begin
            pack_d    = pack_upd;
            bit_cnt_d = bit_cnt_q + BW'(1);
        end

        // A flush on the word-completing cycle has already been covered by the emission above,
        // so only emit here when bits remain that were not just sent.
        if (bus.flush) begin
            chunk_cnt_d = '0;
            acc_d       = '0;
            if (!word_done && (neuron_done || (bit_cnt_q != '0))) begin
                o_val_d    = 1'b1;
                stream_o_d = pack_upd;
                pack_d     = '0;
                bit_cnt_d  = '0;
            end
        end
    end

    // State registers with synchronous reset discarding any partial neuron or word.
    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_cnt_q <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            pack_q      <= '0;
            o_val_q     <= 1'b0;
            stream_o_q  <= '0;
        end else begin
            chunk_cnt_q <= chunk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            pack_q      <= pack_d;
            o_val_q     <= o_val_d;
            stream_o_q  <= stream_o_d;
        end
    end

    assign bus.o_val    = o_val_q;
    assign bus.stream_o = stream_o_q;
endmodule

// File: tb/tb_bin_accum_pack.sv
// Bench for bin_accum_pack: directed table vectors, multi-cycle corner sequences, random stream vs model.
// Latency: checks o_val one cycle after the word-completing edge.
// Backpressure: none to model; inputs are driven on negedge, outputs sampled 1 time unit after posedge.
module tb_bin_accum_pack;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_accum_pack_if #(.IN_W(8), .OUT_W(64)) bus ();

    bin_accum_pack #(
        .IN_W(8), .ACC_W(16), .N_CHUNKS(4), .OUT_W(64), .THRESHOLD(16'sd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    // Reference model: list of completed neuron bits and the running neuron sum.
    int m_cnt;
    int m_sum;
    bit m_bits[$];

    // Capture every emitted word; a stuck or doubled o_val shows up as extra entries.
    always @(posedge clk) begin
        #1;
        if (bus.o_val === 1'b1) got_q.push_back(bus.stream_o);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_emit();
        logic [63:0] w;
        w = '0;
        foreach (m_bits[i]) w[i] = m_bits[i];
        exp_q.push_back(w);
        m_bits.delete();
    endtask

    task automatic drive(input bit iv, input logic [7:0] v, input bit fl);
        @(negedge clk);
        bus.i_val    = iv;
        bus.stream_i = v;
        bus.flush    = fl;
        if (iv) begin
            m_sum += int'($signed(v));
            m_cnt++;
            if (m_cnt == 4) begin
                m_bits.push_back(m_sum >= 0);
                m_cnt = 0;
                m_sum = 0;
                if (m_bits.size() == 64) model_emit();
            end
        end
        if (fl) begin
            m_cnt = 0;
            m_sum = 0;
            if (m_bits.size() > 0) model_emit();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.i_val    = 1'b0;
        bus.flush    = 1'b0;
        bus.stream_i = '0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_sum = 0;
        m_bits.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    // One neuron: chunk k is ch[8k+:8]; optional random idle cycles before each chunk.
    task automatic neuron(input logic [31:0] ch, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive(1'b1, ch[8*k +: 8], 1'b0);
        end
    endtask

    task automatic settle_check(input string name, input int exp_n, input logic [63:0] exp_w);
        idle(3);
        check({name, " count"}, 64'(got_q.size()), 64'(exp_n));
        if (got_q.size() > 0) check({name, " word"}, got_q[$], exp_w);
        got_q.delete();
    endtask

    typedef struct {
        string       name;
        logic [31:0] even_ch;
        logic [31:0] odd_ch;
        bit          gaps;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst          = 1'b1;
        bus.i_val    = 1'b0;
        bus.stream_i = '0;
        bus.flush    = 1'b0;
        m_cnt = 0;
        m_sum = 0;

        vecs[0] = '{"all_zero_sum", 32'hFA00FC0A, 32'hFA00FC0A, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{"alt_pm2",      32'h00000002, 32'h000000FE, 1'b0, 64'h5555_5555_5555_5555};
        vecs[2] = '{"alt_pm2_gaps", 32'h00000002, 32'h000000FE, 1'b1, 64'h5555_5555_5555_5555};
        vecs[3] = '{"all_neg64",    32'hC0C0C0C0, 32'hC0C0C0C0, 1'b0, 64'h0000_0000_0000_0000};
        vecs[4] = '{"all_pos64",    32'h40404040, 32'h40404040, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{"alt_neg_pos",  32'hC0C0C0C0, 32'h40404040, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset o_val", 64'(bus.o_val), 64'd0);
        check("reset stream_o", bus.stream_o, 64'd0);

        // Table vectors: 64 neurons each, one emission expected one cycle after the last chunk.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int n = 0; n < 64; n++) neuron((n % 2 == 0) ? vecs[v].even_ch : vecs[v].odd_ch, vecs[v].gaps);
            @(posedge clk);
            #1;
            check({vecs[v].name, " latency"}, 64'(bus.o_val), 64'd1);
            settle_check(vecs[v].name, 1, vecs[v].exp);
        end

        // Partial word flush, with an incomplete neuron that must not leak into the next word.
        do_reset();
        neuron(32'h00000002, 1'b0);
        neuron(32'h000000FE, 1'b0);
        neuron(32'h00000002, 1'b0);
        drive(1'b1, 8'hC0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        settle_check("flush_partial", 1, 64'h5);
        for (int n = 0; n < 64; n++) neuron(32'h140101EC, 1'b0);
        settle_check("after_flush", 1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset mid-word while stream_o holds a nonzero word.
        for (int n = 0; n < 10; n++) neuron(32'h00000002, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        do_reset();
        #1;
        check("midreset o_val", 64'(bus.o_val), 64'd0);
        check("midreset stream_o", bus.stream_o, 64'd0);
        drive(1'b0, 8'h00, 1'b1);
        settle_check("empty_flush", 0, 64'd0);
        for (int n = 0; n < 63; n++) neuron(32'h000000FE, 1'b0);
        drive(1'b1, 8'hFE, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b1);
        settle_check("flush_on_word_done", 1, 64'd0);

        // Random stream with gaps and occasional flushes against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 199) == 0);
        end
        idle(3);
        check("random count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("random word %0d", i), got_q[i], exp_q[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
